// File: rtl/key_lock_manager_if.sv
// Acquire/release/response bundle between the compute engines and the
// key-lock manager. Clients drive the master side, the manager the slave side.
interface key_lock_manager_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int LOCK_DEPTH  = 8
);
    localparam int CNT_W = $clog2(LOCK_DEPTH + 1);

    logic [NUM_CLIENTS-1:0]           acq_valid;
    logic [NUM_CLIENTS*KEY_WIDTH-1:0] acq_key;
    logic [NUM_CLIENTS-1:0]           rel_valid;
    logic [NUM_CLIENTS*KEY_WIDTH-1:0] rel_key;
    logic [NUM_CLIENTS-1:0]           rsp_valid;
    logic [NUM_CLIENTS-1:0]           rsp_grant;
    logic [NUM_CLIENTS-1:0]           rsp_full;
    logic [CNT_W-1:0]                 lock_count;
    logic                             table_full;

    modport master (
        output acq_valid, acq_key, rel_valid, rel_key,
        input  rsp_valid, rsp_grant, rsp_full, lock_count, table_full
    );

    modport slave (
        input  acq_valid, acq_key, rel_valid, rel_key,
        output rsp_valid, rsp_grant, rsp_full, lock_count, table_full
    );
endinterface

// File: rtl/key_lock_manager.sv
// Key-lock manager: round-robin acquire arbitration over NUM_CLIENTS engines,
// a LOCK_DEPTH-entry table of (valid, key, owner), owner-checked releases
// processed in parallel, and table-full back-pressure on refused acquires.
module key_lock_manager #(
    parameter int NUM_CLIENTS = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int LOCK_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    key_lock_manager_if.slave  bus
);
    localparam int OWN_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(LOCK_DEPTH + 1);
    localparam int IDX_W = (LOCK_DEPTH > 1) ? $clog2(LOCK_DEPTH) : 1;

    // Lock table; only the valid bits are control state and need a reset.
    logic [LOCK_DEPTH-1:0] valid_q, valid_d;
    logic [KEY_WIDTH-1:0]  key_q   [LOCK_DEPTH];
    logic [KEY_WIDTH-1:0]  key_d   [LOCK_DEPTH];
    logic [OWN_W-1:0]      owner_q [LOCK_DEPTH];
    logic [OWN_W-1:0]      owner_d [LOCK_DEPTH];

    logic [OWN_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_CLIENTS-1:0] rsp_grant_q, rsp_grant_d;
    logic [NUM_CLIENTS-1:0] rsp_full_q, rsp_full_d;
    logic [CNT_W-1:0]       lock_count_q, lock_count_d;
    logic                   table_full_q, table_full_d;

    logic [NUM_CLIENTS-1:0] eligible;
    logic                   sel_found;
    logic [OWN_W-1:0]       sel_idx;
    logic [OWN_W-1:0]       cand_idx;
    logic [KEY_WIDTH-1:0]   sel_key;
    int                     cand;

    logic                   hit;
    logic [OWN_W-1:0]       hit_owner;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;

    // Round-robin pick: first eligible client at or after rr_ptr, wrapping.
    always_comb begin
        eligible  = bus.acq_valid & ~rsp_valid_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            cand_idx = OWN_W'(cand);
            if (!sel_found && eligible[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        sel_key = bus.acq_key[sel_idx*KEY_WIDTH +: KEY_WIDTH];
    end

    // Look up the selected key in the start-of-cycle table and find the lowest free slot.
    always_comb begin
        hit        = 1'b0;
        hit_owner  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = 0; e < LOCK_DEPTH; e++) begin
            if (valid_q[e] && (key_q[e] == sel_key)) begin
                hit       = 1'b1;
                hit_owner = owner_q[e];
            end
            if (!valid_q[e] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(e);
            end
        end
    end

    // Next state: owner-checked releases, then the acquire decision and allocation.
    always_comb begin
        valid_d     = valid_q;
        key_d       = key_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        rsp_grant_d = '0;
        rsp_full_d  = '0;

        // Releases only touch currently valid entries, so they never collide
        // with an allocation, which always targets an invalid slot.
        for (int e = 0; e < LOCK_DEPTH; e++) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (bus.rel_valid[c] && valid_q[e] &&
                    (key_q[e] == bus.rel_key[c*KEY_WIDTH +: KEY_WIDTH]) &&
                    (owner_q[e] == OWN_W'(c))) begin
                    valid_d[e] = 1'b0;
                end
            end
        end

        if (sel_found) begin
            rsp_valid_d[sel_idx] = 1'b1;
            rr_ptr_d = (sel_idx == OWN_W'(NUM_CLIENTS - 1)) ? '0 : sel_idx + OWN_W'(1);
            if (hit) begin
                rsp_grant_d[sel_idx] = (hit_owner == sel_idx);
            end else if (free_found) begin
                valid_d[free_idx]    = 1'b1;
                key_d[free_idx]      = sel_key;
                owner_d[free_idx]    = sel_idx;
                rsp_grant_d[sel_idx] = 1'b1;
            end else begin
                rsp_full_d[sel_idx] = 1'b1;
            end
        end

        lock_count_d = '0;
        for (int e = 0; e < LOCK_DEPTH; e++) begin
            lock_count_d = lock_count_d + CNT_W'(valid_d[e]);
        end
        table_full_d = (lock_count_d == CNT_W'(LOCK_DEPTH));
    end

    // Control state with synchronous reset; reset drops every lock and pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            rr_ptr_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_grant_q  <= '0;
            rsp_full_q   <= '0;
            lock_count_q <= '0;
            table_full_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_grant_q  <= rsp_grant_d;
            rsp_full_q   <= rsp_full_d;
            lock_count_q <= lock_count_d;
            table_full_q <= table_full_d;
        end
    end

    // Key and owner payload; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        key_q   <= key_d;
        owner_q <= owner_d;
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_grant  = rsp_grant_q;
    assign bus.rsp_full   = rsp_full_q;
    assign bus.lock_count = lock_count_q;
    assign bus.table_full = table_full_q;
endmodule

// File: tb/tb_key_lock_manager.sv
// Directed bench for key_lock_manager with 4 clients, 32-bit keys, 8 entries.
module tb_key_lock_manager;
    localparam int NC = 4;
    localparam int KW = 32;
    localparam int LD = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    key_lock_manager_if #(.NUM_CLIENTS(NC), .KEY_WIDTH(KW), .LOCK_DEPTH(LD)) bus ();

    key_lock_manager #(.NUM_CLIENTS(NC), .KEY_WIDTH(KW), .LOCK_DEPTH(LD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_acq(input int c, input logic [KW-1:0] k);
        bus.acq_valid[c]          = 1'b1;
        bus.acq_key[c*KW +: KW]   = k;
    endtask

    task automatic clr_acq(input int c);
        bus.acq_valid[c] = 1'b0;
    endtask

    task automatic set_rel(input int c, input logic [KW-1:0] k);
        bus.rel_valid[c]          = 1'b1;
        bus.rel_key[c*KW +: KW]   = k;
    endtask

    task automatic clr_rel(input int c);
        bus.rel_valid[c] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.acq_valid = '0;
        bus.acq_key   = '0;
        bus.rel_valid = '0;
        bus.rel_key   = '0;
        step();
        step();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
        checks++; if (bus.rsp_grant !== 4'b0000) begin errors++; $display("FAIL reset_rsp_grant got=%b exp=0000", bus.rsp_grant); end
        checks++; if (bus.rsp_full !== 4'b0000) begin errors++; $display("FAIL reset_rsp_full got=%b exp=0000", bus.rsp_full); end
        checks++; if (bus.lock_count !== 4'd0) begin errors++; $display("FAIL reset_lock_count got=%0d exp=0", bus.lock_count); end
        checks++; if (bus.table_full !== 1'b0) begin errors++; $display("FAIL reset_table_full got=%b exp=0", bus.table_full); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_grant_refuse();
        set_acq(0, 32'h0000_00A5);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant} !== {4'b0001, 4'b0001}) begin errors++; $display("FAIL c0_grant got=%b/%b exp=0001/0001", bus.rsp_valid, bus.rsp_grant); end
        checks++; if (bus.lock_count !== 4'd1) begin errors++; $display("FAIL c0_lock_count got=%0d exp=1", bus.lock_count); end
        clr_acq(0);
        set_acq(1, 32'h0000_00A5);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== {4'b0010, 4'b0000, 4'b0000}) begin errors++; $display("FAIL c1_refused got=%b/%b/%b exp=0010/0000/0000", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        step();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL c1_no_reselect got=%b exp=0000", bus.rsp_valid); end
        set_rel(0, 32'h0000_00A5);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== {4'b0010, 4'b0000, 4'b0000}) begin errors++; $display("FAIL rel_acq_same_cycle got=%b/%b/%b exp=0010/0000/0000", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        checks++; if (bus.lock_count !== 4'd0) begin errors++; $display("FAIL rel_lock_count got=%0d exp=0", bus.lock_count); end
        clr_rel(0);
        step();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL c1_gap got=%b exp=0000", bus.rsp_valid); end
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant} !== {4'b0010, 4'b0010}) begin errors++; $display("FAIL c1_retry_grant got=%b/%b exp=0010/0010", bus.rsp_valid, bus.rsp_grant); end
        checks++; if (bus.lock_count !== 4'd1) begin errors++; $display("FAIL c1_lock_count got=%0d exp=1", bus.lock_count); end
        clr_acq(1);
        // Client 0 no longer owns 0xA5: its release must be ignored.
        set_rel(0, 32'h0000_00A5);
        step();
        checks++; if (bus.lock_count !== 4'd1) begin errors++; $display("FAIL old_owner_rel got=%0d exp=1", bus.lock_count); end
        clr_rel(0);
        set_rel(1, 32'h0000_00A5);
        step();
        checks++; if (bus.lock_count !== 4'd0) begin errors++; $display("FAIL owner1_rel got=%0d exp=0", bus.lock_count); end
        clr_rel(1);
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        pulse_reset();
        for (int c = 0; c < NC; c++) set_acq(c, 32'h100 + c);
        for (int i = 0; i < 5; i++) begin
            step();
            exp = 4'b0001 << order[i];
            checks++; if ({bus.rsp_valid, bus.rsp_grant} !== {exp, exp}) begin errors++; $display("FAIL rr_step%0d got=%b/%b exp=%b/%b", i, bus.rsp_valid, bus.rsp_grant, exp, exp); end
            if (i > 0 && i < 4) clr_acq(order[i]);
        end
        checks++; if (bus.lock_count !== 4'd4) begin errors++; $display("FAIL rr_lock_count got=%0d exp=4", bus.lock_count); end
        bus.acq_valid = '0;
        step();
    endtask

    task automatic test_table_full();
        pulse_reset();
        for (int k = 0; k < LD; k++) begin
            set_acq(0, 32'h200 + k);
            step();
            checks++; if ({bus.rsp_valid, bus.rsp_grant} !== {4'b0001, 4'b0001}) begin errors++; $display("FAIL fill%0d got=%b/%b exp=0001/0001", k, bus.rsp_valid, bus.rsp_grant); end
            clr_acq(0);
            step();
        end
        checks++; if ({bus.lock_count, bus.table_full} !== {4'd8, 1'b1}) begin errors++; $display("FAIL filled got=%0d/%b exp=8/1", bus.lock_count, bus.table_full); end
        set_acq(1, 32'h2FF);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== {4'b0010, 4'b0000, 4'b0010}) begin errors++; $display("FAIL ninth_refused got=%b/%b/%b exp=0010/0000/0010", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        set_rel(0, 32'h203);
        step();
        checks++; if ({bus.rsp_valid, bus.lock_count, bus.table_full} !== {4'b0000, 4'd7, 1'b0}) begin errors++; $display("FAIL free_one got=%b/%0d/%b exp=0000/7/0", bus.rsp_valid, bus.lock_count, bus.table_full); end
        clr_rel(0);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== {4'b0010, 4'b0010, 4'b0000}) begin errors++; $display("FAIL ninth_retry got=%b/%b/%b exp=0010/0010/0000", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        checks++; if ({bus.lock_count, bus.table_full} !== {4'd8, 1'b1}) begin errors++; $display("FAIL refilled got=%0d/%b exp=8/1", bus.lock_count, bus.table_full); end
        clr_acq(1);
        step();
        // Release frees a slot in the same cycle an acquire needs it: still refused as full.
        set_acq(2, 32'h3AA);
        set_rel(1, 32'h2FF);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== {4'b0100, 4'b0000, 4'b0100}) begin errors++; $display("FAIL full_same_cycle got=%b/%b/%b exp=0100/0000/0100", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        checks++; if (bus.lock_count !== 4'd7) begin errors++; $display("FAIL full_same_cycle_cnt got=%0d exp=7", bus.lock_count); end
        clr_acq(2);
        clr_rel(1);
        step();
    endtask

    task automatic test_non_owner();
        set_rel(2, 32'h200);
        step();
        checks++; if ({bus.rsp_valid, bus.lock_count} !== {4'b0000, 4'd7}) begin errors++; $display("FAIL non_owner_rel got=%b/%0d exp=0000/7", bus.rsp_valid, bus.lock_count); end
        clr_rel(2);
        set_acq(0, 32'h200);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant} !== {4'b0001, 4'b0001}) begin errors++; $display("FAIL reacquire got=%b/%b exp=0001/0001", bus.rsp_valid, bus.rsp_grant); end
        checks++; if (bus.lock_count !== 4'd7) begin errors++; $display("FAIL reacquire_cnt got=%0d exp=7", bus.lock_count); end
        clr_acq(0);
        step();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            set_acq(0, 32'h500 + k);
            step();
            clr_acq(0);
            step();
        end
        checks++; if (bus.lock_count !== 4'd5) begin errors++; $display("FAIL five_held got=%0d exp=5", bus.lock_count); end
        set_acq(1, 32'h600);
        set_acq(2, 32'h601);
        reset = 1'b1;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.rsp_full} !== 12'b0) begin errors++; $display("FAIL midreset_rsp got=%b/%b/%b exp=0000/0000/0000", bus.rsp_valid, bus.rsp_grant, bus.rsp_full); end
        checks++; if ({bus.lock_count, bus.table_full} !== {4'd0, 1'b0}) begin errors++; $display("FAIL midreset_cnt got=%0d/%b exp=0/0", bus.lock_count, bus.table_full); end
        reset = 1'b0;
        clr_acq(1);
        clr_acq(2);
        step();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL midreset_no_rsp got=%b exp=0000", bus.rsp_valid); end
        // Locks were lost, so another client can take a formerly held key.
        set_acq(1, 32'h500);
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_grant, bus.lock_count} !== {4'b0010, 4'b0010, 4'd1}) begin errors++; $display("FAIL after_reset_grant got=%b/%b/%0d exp=0010/0010/1", bus.rsp_valid, bus.rsp_grant, bus.lock_count); end
        clr_acq(1);
        step();
    endtask

    initial begin
        test_reset();
        test_grant_refuse();
        test_round_robin();
        test_table_full();
        test_non_owner();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/key_lock_manager.md
# key_lock_manager

Parametrised key-lock manager for the accumulate/compute datapath: any of NUM_CLIENTS engines (accumulate, update, fill, …) acquire and release exclusive ownership of 32-bit keys held in a shared LOCK_DEPTH-entry lock table. It replaces the fixed two-party toggle grant with round-robin arbitration over N clients, explicit acquire/release handshakes, owner tracking and table-full back-pressure. It sits between the compute engines and the key/value store, alongside the sort and accumulate blocks.

## Interface
- NUM_CLIENTS, 4, number of requesting engines (2..16)
- KEY_WIDTH, 32, key width in bits
- LOCK_DEPTH, 8, lock-table entries (1..32)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- acq_valid  in  NUM_CLIENTS  per-client acquire request, held until rsp_valid
- acq_key  in  NUM_CLIENTS*KEY_WIDTH  acquire keys, client c at [KEY_WIDTH*(c+1)-1:KEY_WIDTH*c]
- rel_valid  in  NUM_CLIENTS  per-client single-cycle release strobe
- rel_key  in  NUM_CLIENTS*KEY_WIDTH  release keys, same packing
- rsp_valid  out  NUM_CLIENTS  one-cycle acquire response pulse
- rsp_grant  out  NUM_CLIENTS  qualified by rsp_valid: 1 = lock held, 0 = refused
- rsp_full  out  NUM_CLIENTS  qualified by rsp_valid: refused because table full
- lock_count  out  $clog2(LOCK_DEPTH+1)  number of valid entries
- table_full  out  1  lock_count == LOCK_DEPTH

## Operation
- Table entry: valid, key, owner (log2 NUM_CLIENTS bits). Reset clears all valid bits.
- Eligible clients: acq_valid[c] && !rsp_valid[c] (a client with a response on the wire is not re-selected that cycle).
- Round-robin arbiter: search starts at rr_ptr; lowest eligible index ≥ rr_ptr, else wraps. One acquire serviced per cycle. After service, rr_ptr = selected+1 mod NUM_CLIENTS; unchanged when none eligible.
- Lookup of the selected key against the table state at the start of the cycle:
  - hit, owner == requester: grant (idempotent, no new entry)
  - hit, owner != requester: refuse, rsp_full=0
  - miss, free entry exists: allocate lowest-index free entry, grant
  - miss, table full: refuse, rsp_full=1
- Releases: every rel_valid[c] processed in the same cycle, no arbitration. Clears any entry with key == rel_key[c] and owner == c. Release by a non-owner or of an absent key is ignored.
- Same-cycle release and acquire of the same key: acquire sees the pre-release table (refused if held by another); entry is free from the next cycle. Release freeing the slot the acquire would need when full: acquire still refused with rsp_full=1.
- Allocation and release of different entries in one cycle both take effect; lock_count updated by +alloc −releases.
- Refused clients retry by keeping acq_valid high; they become eligible again the cycle after their rsp_valid.

## Timing
- Reset values: rsp_valid=0, rsp_grant=0, rsp_full=0, lock_count=0, table_full=0, rr_ptr=0, all entries invalid.
- Acquire latency: selected in cycle t, rsp_* registered and table updated at edge ending t, visible in t+1. Minimum request-to-response 1 cycle.
- Release latency: entry invalid and lock_count updated in cycle after rel_valid.
- Per-client throughput: at most one response every 2 cycles; aggregate one response per cycle.
- rsp_valid is one-hot or zero per cycle.
- Reset mid-operation: pending requests dropped, no response issued, all locks lost; clients must re-acquire.
- Client drops acq_valid before response: request is simply not selected; no response.

## Test plan
- After reset, client 0 acquires 0x0000_00A5 -> rsp_valid[0], rsp_grant[0]=1 in cycle t+1, lock_count=1.
- Client 1 then acquires 0x0000_00A5 -> rsp_grant[1]=0, rsp_full[1]=0; client 0 releases 0xA5 while client 1 retries same cycle -> refused, next retry granted, owner=1.
- All 4 clients hold acq_valid with distinct keys from cycle 0 -> responses to clients 0,1,2,3 in consecutive cycles, then rr wraps to 0.
- LOCK_DEPTH=8: fill with 8 distinct keys -> table_full=1; 9th key -> rsp_grant=0, rsp_full=1; release one key -> lock_count=7, retry granted.
- Client 2 releases key owned by client 3 -> ignored, lock_count unchanged; client 0 re-acquires own key -> granted, lock_count unchanged.
- Assert reset with 5 locks held and 2 requests pending -> next cycle all outputs 0, lock_count=0, no rsp_valid.
